// File: rtl/disk_track_loader.sv
// Track cache loader: streams one track image between SD blocks and the drive's track buffer.
// Define TRACK_WRITEBACK_EN to enable dirty tracking and write-back (FLUSH) of modified tracks.
module disk_track_loader #(
  parameter int SECTORS_PER_TRACK = 13
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [5:0]  track,
  input  logic        img_mounted,
  input  logic [63:0] img_size,
  input  logic        img_readonly,
  input  logic        disk_we,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [3:0]  track_sec,
  output logic        cpu_wait,
  output logic        busy,
  output logic        dirty
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [31:0] SPT32    = 32'(SECTORS_PER_TRACK);
  localparam logic [3:0]  LAST_SEC = 4'(SECTORS_PER_TRACK - 1);

  state_t      state_r;
  logic [5:0]  cur_track_r;
  logic [5:0]  target_r;
  logic        valid_r;
  logic        mount_pending_r;
  logic        ack_d_r;
  logic [31:0] sd_lba_r;
  logic        sd_rd_r;
  logic        sd_wr_r;
  logic [3:0]  track_sec_r;
  logic        cpu_wait_r;
  logic        busy_r;
  logic        dirty_r;

  logic ack_rise_s;
  logic ack_fall_s;
  logic last_s;
  logic start_s;
  logic flush_s;

  function automatic logic [31:0] track_lba(input logic [5:0] t);
    return SPT32 * {26'd0, t};
  endfunction

  assign ack_rise_s = sd_ack & ~ack_d_r;
  assign ack_fall_s = ~sd_ack & ack_d_r;
  assign last_s     = (track_sec_r == LAST_SEC);
  assign start_s    = (state_r == IDLE) && (img_size != 64'd0) &&
                      ((track != cur_track_r) || !valid_r || mount_pending_r);

`ifdef TRACK_WRITEBACK_EN
  logic set_dirty_s;
  logic flush_end_s;

  assign flush_s     = dirty_r && !img_readonly;
  assign set_dirty_s = (state_r == IDLE) && !start_s && disk_we && valid_r && !img_readonly;
  assign flush_end_s = (state_r == FLUSH) && ack_fall_s && !sd_wr_r;

  // Write strobe and dirty flag; a new mount discards buffered writes without flushing.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sd_wr_r <= 1'b0;
      dirty_r <= 1'b0;
    end else begin
      if (start_s && flush_s) begin
        sd_wr_r <= 1'b1;
      end else if ((state_r == FLUSH) && ack_rise_s && last_s) begin
        sd_wr_r <= 1'b0;
      end else begin
        sd_wr_r <= sd_wr_r;
      end
      if (img_mounted || flush_end_s) begin
        dirty_r <= 1'b0;
      end else if (set_dirty_s) begin
        dirty_r <= 1'b1;
      end else begin
        dirty_r <= dirty_r;
      end
    end
  end
`else
  logic unused_wb;

  assign flush_s   = 1'b0;
  assign sd_wr_r   = 1'b0;
  assign dirty_r   = 1'b0;
  assign unused_wb = &{1'b0, disk_we, img_readonly};
`endif

  // Transfer sequencer: strobe stays high across sectors, each ack pulse advances one block.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r         <= IDLE;
      cur_track_r     <= 6'd0;
      target_r        <= 6'd0;
      valid_r         <= 1'b0;
      mount_pending_r <= 1'b0;
      ack_d_r         <= 1'b0;
      sd_lba_r        <= 32'd0;
      sd_rd_r         <= 1'b0;
      track_sec_r     <= 4'd0;
      cpu_wait_r      <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      ack_d_r <= sd_ack;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            target_r        <= track;
            mount_pending_r <= 1'b0;
            cpu_wait_r      <= 1'b1;
            busy_r          <= 1'b1;
            track_sec_r     <= 4'd0;
            if (flush_s) begin
              state_r  <= FLUSH;
              sd_lba_r <= track_lba(cur_track_r);
            end else begin
              state_r  <= LOAD;
              sd_rd_r  <= 1'b1;
              sd_lba_r <= track_lba(track);
            end
          end
        end
        LOAD: begin
          if (ack_rise_s) begin
            sd_lba_r <= sd_lba_r + 32'd1;
            if (last_s) sd_rd_r <= 1'b0;
          end
          if (ack_fall_s) begin
            track_sec_r <= track_sec_r + 4'd1;
            if (!sd_rd_r) begin
              state_r     <= IDLE;
              cur_track_r <= target_r;
              valid_r     <= 1'b1;
              cpu_wait_r  <= 1'b0;
              busy_r      <= 1'b0;
            end
          end
        end
`ifdef TRACK_WRITEBACK_EN
        FLUSH: begin
          if (ack_rise_s) sd_lba_r <= sd_lba_r + 32'd1;
          if (ack_fall_s) begin
            track_sec_r <= track_sec_r + 4'd1;
            if (!sd_wr_r) begin
              // Old track written back; reload the latched target immediately.
              state_r     <= LOAD;
              sd_rd_r     <= 1'b1;
              sd_lba_r    <= track_lba(target_r);
              track_sec_r <= 4'd0;
            end
          end
        end
`endif
        default: begin
          state_r <= IDLE;
        end
      endcase
      // A mount coinciding with a start is served by that load, so it leaves nothing pending.
      if (img_mounted && !start_s) mount_pending_r <= 1'b1;
    end
  end

  assign sd_lba    = sd_lba_r;
  assign sd_rd     = sd_rd_r;
  assign sd_wr     = sd_wr_r;
  assign track_sec = track_sec_r;
  assign cpu_wait  = cpu_wait_r;
  assign busy      = busy_r;
  assign dirty     = dirty_r;

endmodule

// File: tb/tb_disk_track_loader.sv
// Directed bench for disk_track_loader: vector table of track changes plus hand-written
// sequences for mount, read-only, write-back, mid-transfer mount and reset cases.
module tb_disk_track_loader;

  localparam int SPT = 13;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [5:0]  track;
  logic        img_mounted;
  logic [63:0] img_size;
  logic        img_readonly;
  logic        disk_we;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic [3:0]  track_sec;
  logic        cpu_wait;
  logic        busy;
  logic        dirty;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0] trk;
    bit         load;
    int         lba;
  } vec_t;

  vec_t vecs[5];

  disk_track_loader #(.SECTORS_PER_TRACK(SPT)) dut (
    .clk_sys(clk_sys), .reset(reset), .track(track), .img_mounted(img_mounted),
    .img_size(img_size), .img_readonly(img_readonly), .disk_we(disk_we), .sd_ack(sd_ack),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .track_sec(track_sec),
    .cpu_wait(cpu_wait), .busy(busy), .dirty(dirty)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Emulates the SD host: serves nsec blocks; a partial count stops on the last sector unacked.
  task automatic serve(input bit is_wr, input int base, input int nsec);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if ((is_wr ? sd_wr : sd_rd) === 1'b1) ok = 1'b1;
      else tick(1);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL strobe_timeout: got no %s strobe expected one at lba %0d",
               is_wr ? "wr" : "rd", base);
      return;
    end
    for (int i = 0; i < nsec; i++) begin
      check("lba", sd_lba, 32'(base + i));
      check("track_sec", {28'd0, track_sec}, 32'(i));
      check("cpu_wait_busy", {31'd0, cpu_wait & busy}, 32'd1);
      check("other_strobe", {31'd0, is_wr ? sd_rd : sd_wr}, 32'd0);
      if (i == nsec - 1 && nsec < SPT) return;
      sd_ack = 1'b1;
      tick(2);
      sd_ack = 1'b0;
      tick(1);
      check("track_sec_inc", {28'd0, track_sec}, 32'(i + 1));
    end
    check("strobe_drop", {31'd0, is_wr ? sd_wr : sd_rd}, 32'd0);
    if (!is_wr) begin
      check("cpu_wait_end", {31'd0, cpu_wait}, 32'd0);
      check("busy_end", {31'd0, busy}, 32'd0);
    end else begin
      check("dirty_cleared", {31'd0, dirty}, 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{trk: 6'd17, load: 1'b1, lba: 221};
    vecs[1] = '{trk: 6'd17, load: 1'b0, lba: 0};
    vecs[2] = '{trk: 6'd34, load: 1'b1, lba: 442};
    vecs[3] = '{trk: 6'd63, load: 1'b1, lba: 819};
    vecs[4] = '{trk: 6'd3,  load: 1'b1, lba: 39};

    reset = 1'b1; track = 6'd0; img_mounted = 1'b0; img_size = 64'd0;
    img_readonly = 1'b0; disk_we = 1'b0; sd_ack = 1'b0;
    tick(3);
    check("rst_sd_rd", {31'd0, sd_rd}, 32'd0);
    check("rst_sd_wr", {31'd0, sd_wr}, 32'd0);
    check("rst_cpu_wait", {31'd0, cpu_wait}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dirty", {31'd0, dirty}, 32'd0);
    check("rst_track_sec", {28'd0, track_sec}, 32'd0);
    check("rst_lba", sd_lba, 32'd0);

    // No image: track changes are ignored
    reset = 1'b0;
    tick(1);
    track = 6'd5;
    tick(4);
    check("noimg_sd_rd", {31'd0, sd_rd}, 32'd0);
    check("noimg_cpu_wait", {31'd0, cpu_wait}, 32'd0);
    check("noimg_busy", {31'd0, busy}, 32'd0);

    // Mount an image at track 0: 13 blocks from lba 0
    track = 6'd0; img_size = 64'd143360; img_mounted = 1'b1;
    tick(1);
    img_mounted = 1'b0;
    serve(1'b0, 0, SPT);

    // Read-only image: disk writes never mark the track dirty
    img_readonly = 1'b1; disk_we = 1'b1;
    tick(1);
    disk_we = 1'b0;
    tick(1);
    check("ro_dirty", {31'd0, dirty}, 32'd0);
    track = 6'd2;
    tick(1);
    check("ro_no_wr", {31'd0, sd_wr}, 32'd0);
    serve(1'b0, 26, SPT);
    img_readonly = 1'b0;

    for (int v = 0; v < 5; v++) begin
      track = vecs[v].trk;
      if (vecs[v].load) begin
        serve(1'b0, vecs[v].lba, SPT);
      end else begin
        tick(3);
        check("same_track_rd", {31'd0, sd_rd}, 32'd0);
        check("same_track_busy", {31'd0, busy}, 32'd0);
      end
    end

    // Write into track 3, then move to track 4
    disk_we = 1'b1;
    tick(1);
    disk_we = 1'b0;
`ifdef TRACK_WRITEBACK_EN
    check("wb_dirty_set", {31'd0, dirty}, 32'd1);
    track = 6'd4;
    serve(1'b1, 39, SPT);
    serve(1'b0, 52, SPT);
`else
    check("nowb_dirty", {31'd0, dirty}, 32'd0);
    track = 6'd4;
    tick(1);
    check("nowb_no_wr", {31'd0, sd_wr}, 32'd0);
    serve(1'b0, 52, SPT);
`endif

    // Mount arriving mid-load: load completes, then the same track reloads
    track = 6'd5;
    tick(1);
    img_mounted = 1'b1;
    tick(1);
    img_mounted = 1'b0;
    serve(1'b0, 65, SPT);
    serve(1'b0, 65, SPT);

    // Reset while the fifth sector is requested, then a full reload after release
    track = 6'd6;
    serve(1'b0, 78, 5);
    reset = 1'b1;
    tick(1);
    check("midrst_sd_rd", {31'd0, sd_rd}, 32'd0);
    check("midrst_cpu_wait", {31'd0, cpu_wait}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_track_sec", {28'd0, track_sec}, 32'd0);
    reset = 1'b0;
    serve(1'b0, 78, SPT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disk_track_loader.md
DISK_TRACK_LOADER -- requirements
Module: disk_track_loader

Interface
REQ-001 SHALL have parameter SECTORS_PER_TRACK, default 13, giving the number of 256-byte-pair (512-byte) SD blocks per track image.
REQ-002 SHALL have ports: clk_sys in 1, system clock; reset in 1, synchronous active-high reset.
REQ-003 SHALL have ports: track in 6, track requested by drive; img_mounted in 1, mount pulse; img_size in 64, image size; img_readonly in 1, image write-protect.
REQ-004 SHALL have ports: disk_we in 1, CPU-side write strobe into track buffer; sd_ack in 1, hps_io block acknowledge.
REQ-005 SHALL have ports: sd_lba out 32, block address; sd_rd out 1; sd_wr out 1; track_sec out 4, buffer sector index (high address bits); cpu_wait out 1; busy out 1; dirty out 1.

Function
REQ-006 SHALL implement states IDLE, FLUSH, LOAD; FLUSH exists only per REQ-020.
REQ-007 SHALL hold cur_track (6 bits) and valid flag; valid=0 forces a load when img_size is nonzero.
REQ-008 In IDLE, SHALL start a transfer when (track != cur_track or valid=0 or mount pending) and img_size != 0; ignore requests while img_size == 0.
REQ-009 On start, SHALL enter FLUSH if dirty and not readonly, else LOAD; latch target track at start.
REQ-010 SHALL set sd_lba = SECTORS_PER_TRACK * track (32-bit, zero-extended) at start of LOAD or FLUSH (FLUSH uses cur_track), track_sec = 0.
REQ-011 SHALL hold sd_rd (LOAD) or sd_wr (FLUSH) high until sd_ack rising edge; on that edge, drop the strobe if track_sec == SECTORS_PER_TRACK-1, and increment sd_lba.
REQ-012 On sd_ack falling edge, SHALL increment track_sec; if the strobe is already low, the phase ends.
REQ-013 After FLUSH ends, SHALL clear dirty and enter LOAD for latched target track, next cycle.
REQ-014 After LOAD ends, SHALL set cur_track = target, valid = 1, return to IDLE.
REQ-015 SHALL assert cpu_wait and busy from the start cycle until return to IDLE, continuously across all sectors and both phases.
REQ-016 track change during FLUSH/LOAD SHALL not abort; it is detected in IDLE after completion (REQ-008).
REQ-017 img_mounted pulse SHALL set mount pending, clear dirty (new image content discarded, no flush); if busy, the current phase completes and a reload follows.
REQ-018 track_sec SHALL wrap 4 bits only via reset to 0 at phase start; never exceeds SECTORS_PER_TRACK.
REQ-019 sd_rd and sd_wr SHALL never be high simultaneously.

Configuration
REQ-020 With macro TRACK_WRITEBACK_EN defined: disk_we in IDLE with valid=1 and not img_readonly sets dirty; FLUSH state present. Without it: dirty tied 0, sd_wr tied 0, disk_we ignored, FLUSH absent.

Reset
REQ-021 On reset SHALL: state IDLE, sd_rd=0, sd_wr=0, cpu_wait=0, busy=0, dirty=0, track_sec=0, sd_lba=0, valid=0, mount pending=0; reset mid-transfer abandons the transfer, strobes low next cycle.
REQ-022 After reset release, SHALL reload the current track if img_size != 0.

Verification
REQ-023 img_size=143360, mount pulse, track=0 -> sd_rd high, 13 ack pulses, sd_lba 0..12, track_sec 0..13, cpu_wait low after 13th ack falls.
REQ-024 track 0->17 in IDLE -> sd_lba starts 221, ends 233; cur_track=17.
REQ-025 (TRACK_WRITEBACK_EN) disk_we on track 3, then track=4 -> sd_wr lbas 39..51, dirty cleared, then sd_rd lbas 52..64.
REQ-026 img_readonly=1, disk_we, track change -> dirty stays 0, no sd_wr, direct load.
REQ-027 reset asserted during 5th sector of load -> sd_rd=0, cpu_wait=0 next cycle; after release full reload of current track from sector 0.
REQ-028 img_size=0, track change -> sd_rd, cpu_wait remain 0.
